// File: rtl/axis_split_ctrl.sv
// axis_split_ctrl: registered 1-to-N AXI-Stream broadcast with per-port acceptance tracking, stall timeout and saturating drop counters
module axis_split_ctrl #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int N_PORTS = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_DATA_tdata,
  input  logic                        S_AXIS_DATA_tvalid,
  output logic                        S_AXIS_DATA_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_COPY1_tdata,
  output logic                        M_AXIS_COPY1_tvalid,
  input  logic                        M_AXIS_COPY1_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_COPY2_tdata,
  output logic                        M_AXIS_COPY2_tvalid,
  input  logic                        M_AXIS_COPY2_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_COPY3_tdata,
  output logic                        M_AXIS_COPY3_tvalid,
  input  logic                        M_AXIS_COPY3_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_COPY4_tdata,
  output logic                        M_AXIS_COPY4_tvalid,
  input  logic                        M_AXIS_COPY4_tready,
  input  logic [3:0]                  port_en,
  input  logic                        clr_cnt,
  output logic                        busy,
  output logic [4*CNT_WIDTH-1:0]      drop_cnt,
  output logic [CNT_WIDTH-1:0]        discard_cnt
);
  localparam int AW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES);
  localparam logic [3:0] ACT = 4'((5'd1 << N_PORTS) - 5'd1);
  logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic [3:0] pend_q, pend_d;
  logic [AW-1:0] age_q, age_d;
  logic [3:0][CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] disc_q, disc_d;
  logic [3:0] rdy, hs, stuck, new_mask;
  logic expire, accept;
  assign rdy = {M_AXIS_COPY4_tready, M_AXIS_COPY3_tready, M_AXIS_COPY2_tready, M_AXIS_COPY1_tready} & ACT;
  assign hs = pend_q & rdy;
  assign stuck = pend_q & ~hs;
  assign expire = (TIMEOUT_CYCLES != 0) && (age_q == AGE_MAX) && |stuck;
  assign S_AXIS_DATA_tready = ~|stuck | expire;
  assign accept = S_AXIS_DATA_tvalid & S_AXIS_DATA_tready;
  assign new_mask = port_en & ACT;
  always_comb begin
    data_d = accept ? S_AXIS_DATA_tdata : data_q;
    pend_d = accept ? new_mask : expire ? 4'h0 : pend_q & ~hs;
    age_d = accept ? '0 : (|pend_q && age_q != AGE_MAX) ? age_q + 1'b1 : age_q;
    disc_d = clr_cnt ? '0 : (accept && new_mask == 4'h0 && ~&disc_q) ? disc_q + 1'b1 : disc_q;
    for (int i = 0; i < 4; i++)
      drop_d[i] = clr_cnt ? '0 : (expire && stuck[i] && ~&drop_q[i]) ? drop_q[i] + 1'b1 : drop_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= '0;
      age_q <= '0;
      drop_q <= '0;
      disc_q <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
      age_q <= age_d;
      drop_q <= drop_d;
      disc_q <= disc_d;
    end
  end
  assign M_AXIS_COPY1_tvalid = pend_q[0];
  assign M_AXIS_COPY2_tvalid = pend_q[1];
  assign M_AXIS_COPY3_tvalid = pend_q[2];
  assign M_AXIS_COPY4_tvalid = pend_q[3];
  assign M_AXIS_COPY1_tdata = ACT[0] ? data_q : '0;
  assign M_AXIS_COPY2_tdata = ACT[1] ? data_q : '0;
  assign M_AXIS_COPY3_tdata = ACT[2] ? data_q : '0;
  assign M_AXIS_COPY4_tdata = ACT[3] ? data_q : '0;
  assign busy = |pend_q;
  assign drop_cnt = drop_q;
  assign discard_cnt = disc_q;
endmodule

// File: tb/tb_axis_split_ctrl.sv
// tb_axis_split_ctrl: scoreboard bench driving a 4-port untimed instance and a 2-port timeout instance side by side
module tb_axis_split_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i [2];
  logic in_v [2];
  logic [31:0] in_d [2];
  logic [3:0] rdy [2];
  logic [3:0] pe [2];
  logic clr [2];
  logic s_r [2];
  logic [3:0] vo [2];
  logic [31:0] dd [2][4];
  logic bsy [2];
  logic [63:0] drop_a;
  logic [11:0] drop_b;
  logic [15:0] disc_a;
  logic [2:0] disc_b;
  logic [31:0] sb [8][$];
  int exp_drop [2][4];
  int exp_disc [2];
  int since [2];
  logic chk_en = 1'b0;
  int total = 0;
  int bad = 0;

  axis_split_ctrl #(.AXIS_TDATA_WIDTH(32), .N_PORTS(4), .TIMEOUT_CYCLES(0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_i[0]),
    .S_AXIS_DATA_tdata(in_d[0]), .S_AXIS_DATA_tvalid(in_v[0]), .S_AXIS_DATA_tready(s_r[0]),
    .M_AXIS_COPY1_tdata(dd[0][0]), .M_AXIS_COPY1_tvalid(vo[0][0]), .M_AXIS_COPY1_tready(rdy[0][0]),
    .M_AXIS_COPY2_tdata(dd[0][1]), .M_AXIS_COPY2_tvalid(vo[0][1]), .M_AXIS_COPY2_tready(rdy[0][1]),
    .M_AXIS_COPY3_tdata(dd[0][2]), .M_AXIS_COPY3_tvalid(vo[0][2]), .M_AXIS_COPY3_tready(rdy[0][2]),
    .M_AXIS_COPY4_tdata(dd[0][3]), .M_AXIS_COPY4_tvalid(vo[0][3]), .M_AXIS_COPY4_tready(rdy[0][3]),
    .port_en(pe[0]), .clr_cnt(clr[0]), .busy(bsy[0]), .drop_cnt(drop_a), .discard_cnt(disc_a)
  );

  axis_split_ctrl #(.AXIS_TDATA_WIDTH(32), .N_PORTS(2), .TIMEOUT_CYCLES(4), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst_i[1]),
    .S_AXIS_DATA_tdata(in_d[1]), .S_AXIS_DATA_tvalid(in_v[1]), .S_AXIS_DATA_tready(s_r[1]),
    .M_AXIS_COPY1_tdata(dd[1][0]), .M_AXIS_COPY1_tvalid(vo[1][0]), .M_AXIS_COPY1_tready(rdy[1][0]),
    .M_AXIS_COPY2_tdata(dd[1][1]), .M_AXIS_COPY2_tvalid(vo[1][1]), .M_AXIS_COPY2_tready(rdy[1][1]),
    .M_AXIS_COPY3_tdata(dd[1][2]), .M_AXIS_COPY3_tvalid(vo[1][2]), .M_AXIS_COPY3_tready(rdy[1][2]),
    .M_AXIS_COPY4_tdata(dd[1][3]), .M_AXIS_COPY4_tvalid(vo[1][3]), .M_AXIS_COPY4_tready(rdy[1][3]),
    .port_en(pe[1]), .clr_cnt(clr[1]), .busy(bsy[1]), .drop_cnt(drop_b), .discard_cnt(disc_b)
  );

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: actual=%0h expected=%0h", n, got, exp);
    end
  endtask

  // Reference model: each copy port owes the beats queued for it; a beat still owed
  // by a non-ready port TIMEOUT cycles after acceptance is abandoned and counted.
  task automatic check_dut(input int d);
    logic [3:0] am;
    logic [3:0] mask;
    logic [15:0] dc;
    int tmo, cmax;
    logic owed, stalled, expire, want_r;
    am = d == 0 ? 4'hF : 4'h3;
    tmo = d == 0 ? 0 : 4;
    cmax = d == 0 ? 65535 : 7;
    owed = 1'b0;
    stalled = 1'b0;
    if (since[d] < 1000) since[d]++;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d_tvalid%0d", d, k + 1), {63'b0, vo[d][k]}, {63'b0, sb[d*4+k].size() != 0});
      if (sb[d*4+k].size() != 0) begin
        chk($sformatf("d%0d_tdata%0d", d, k + 1), {32'b0, dd[d][k]}, {32'b0, sb[d*4+k][0]});
        owed = 1'b1;
        if (!rdy[d][k]) stalled = 1'b1;
      end
      if (!am[k]) chk($sformatf("d%0d_tie%0d", d, k + 1), {32'b0, dd[d][k]}, 64'd0);
      dc = d == 0 ? drop_a[16*k +: 16] : {13'b0, drop_b[3*k +: 3]};
      chk($sformatf("d%0d_drop%0d", d, k + 1), {48'b0, dc}, 64'(exp_drop[d][k]));
    end
    expire = tmo != 0 && since[d] == tmo + 1 && stalled;
    want_r = !stalled || expire;
    chk($sformatf("d%0d_s_tready", d), {63'b0, s_r[d]}, {63'b0, want_r});
    chk($sformatf("d%0d_busy", d), {63'b0, bsy[d]}, {63'b0, owed});
    chk($sformatf("d%0d_discard", d), d == 0 ? {48'b0, disc_a} : {61'b0, disc_b}, 64'(exp_disc[d]));
    if (rst_i[d]) begin
      for (int k = 0; k < 4; k++) begin
        sb[d*4+k].delete();
        exp_drop[d][k] = 0;
      end
      exp_disc[d] = 0;
      return;
    end
    if (clr[d]) begin
      for (int k = 0; k < 4; k++) exp_drop[d][k] = 0;
      exp_disc[d] = 0;
    end
    for (int k = 0; k < 4; k++)
      if (sb[d*4+k].size() != 0 && (rdy[d][k] || expire)) begin
        void'(sb[d*4+k].pop_front());
        if (!rdy[d][k] && !clr[d] && exp_drop[d][k] < cmax) exp_drop[d][k]++;
      end
    if (in_v[d] && want_r) begin
      mask = pe[d] & am;
      since[d] = 0;
      if (mask == 4'h0) begin
        if (!clr[d] && exp_disc[d] < cmax) exp_disc[d]++;
      end else
        for (int k = 0; k < 4; k++) if (mask[k]) sb[d*4+k].push_back(in_d[d]);
    end
  endtask

  always @(negedge clk) if (chk_en) for (int d = 0; d < 2; d++) check_dut(d);

  task automatic drive(input int d, input logic v, input logic [31:0] x, input logic [3:0] r, input logic [3:0] p, input logic c);
    in_v[d] = v;
    in_d[d] = x;
    rdy[d] = r;
    pe[d] = p;
    clr[d] = c;
    @(posedge clk);
    #1;
  endtask

  task automatic seq_a;
    for (int i = 0; i < 8; i++) drive(0, 1, 32'(i), 4'hF, 4'hF, 0);
    drive(0, 0, 0, 4'hF, 4'hF, 0);
    drive(0, 1, 32'h10, 4'hF, 4'hF, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 32'h11, 4'hB, 4'hF, 0);
    drive(0, 1, 32'h11, 4'hF, 4'hF, 0);
    drive(0, 1, 32'h12, 4'hF, 4'hF, 0);
    drive(0, 0, 0, 4'hF, 4'hF, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'hD0 + 32'(i), 4'hF, 4'h0, 0);
    drive(0, 0, 0, 4'hF, 4'h0, 0);
    chk("a_discard3", {48'b0, disc_a}, 64'd3);
    drive(0, 1, 32'hA5, 4'h0, 4'h3, 0);
    drive(0, 0, 0, 4'h0, 4'h3, 0);
    drive(0, 1, 32'h5A, 4'h0, 4'hC, 0);
    drive(0, 1, 32'h5A, 4'hF, 4'hC, 0);
    drive(0, 0, 0, 4'h0, 4'hC, 0);
    drive(0, 0, 0, 4'hF, 4'hC, 0);
    for (int i = 0; i < 400; i++)
      drive(0, $urandom_range(0, 3) != 0, $urandom, 4'($urandom),
            $urandom_range(0, 7) == 0 ? 4'h0 : 4'($urandom), $urandom_range(0, 60) == 0);
    drive(0, 1, 32'hBEEF, 4'h0, 4'hF, 0);
    drive(0, 0, 0, 4'h0, 4'hF, 0);
    rst_i[0] = 1'b1;
    drive(0, 0, 0, 4'h0, 4'hF, 0);
    rst_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 4'hF, 4'hF, 0);
  endtask

  task automatic seq_b;
    for (int i = 0; i < 6; i++) drive(1, 1, 32'h100 + 32'(i), 4'hF, 4'hF, 0);
    for (int i = 0; i < 50; i++) drive(1, 1, 32'h200 + 32'(i), 4'hD, 4'hF, 0);
    drive(1, 0, 0, 4'hD, 4'hF, 0);
    drive(1, 0, 0, 4'hF, 4'hF, 0);
    chk("b_drop2_sat", {61'b0, drop_b[5:3]}, 64'd7);
    drive(1, 0, 0, 4'hF, 4'hF, 1);
    drive(1, 0, 0, 4'hF, 4'hF, 0);
    chk("b_drop2_clr", {61'b0, drop_b[5:3]}, 64'd0);
    for (int i = 0; i < 400; i++)
      drive(1, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF,
            $urandom_range(0, 7) == 0 ? 4'h0 : 4'($urandom), $urandom_range(0, 80) == 0);
    drive(1, 1, 32'hCAFE, 4'h0, 4'hF, 0);
    drive(1, 0, 0, 4'h0, 4'hF, 0);
    rst_i[1] = 1'b1;
    drive(1, 0, 0, 4'h0, 4'hF, 0);
    rst_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'hF, 4'hF, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1;
      in_v[d] = 1'b0;
      in_d[d] = '0;
      rdy[d] = 4'hF;
      pe[d] = 4'hF;
      clr[d] = 1'b0;
      exp_disc[d] = 0;
      since[d] = 1000;
      for (int k = 0; k < 4; k++) exp_drop[d][k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;
    chk_en = 1'b1;
    fork
      seq_a();
      seq_b();
    join
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_split_ctrl.md
# axis_split_ctrl

Handshake-correct AXI-Stream broadcast controller replacing the combinational splitter on the TDATA fan-out path. It registers each input beat once and presents it to up to four copy ports, tracking per-port acceptance so that a beat leaves the slave side only after every enabled copy port has taken it. A per-port runtime enable mask, an optional stall timeout and saturating per-port drop counters let the PS-side control logic detach or diagnose a stuck consumer without halting the others.

## Interface
- AXIS_TDATA_WIDTH, 32, beat width in bits
- N_PORTS, 4, active copy ports (2..4); ports k > N_PORTS are tied off
- TIMEOUT_CYCLES, 0, max cycles a beat may stay pending; 0 disables timeout
- CNT_WIDTH, 16, width of each drop counter

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- S_AXIS_DATA_tdata  in  AXIS_TDATA_WIDTH  input beat
- S_AXIS_DATA_tvalid  in  1  input valid
- S_AXIS_DATA_tready  out  1  input ready
- M_AXIS_COPYk_tdata  out  AXIS_TDATA_WIDTH  copy k data, k = 1..4
- M_AXIS_COPYk_tvalid  out  1  copy k valid
- M_AXIS_COPYk_tready  in  1  copy k ready
- port_en  in  4  bit k-1 enables copy k; sampled only at input accept
- clr_cnt  in  1  synchronous clear of all drop counters and discard_cnt
- busy  out  1  a beat is pending on at least one port
- drop_cnt  out  4*CNT_WIDTH  per-port timeout drop counters, port 1 in LSBs
- discard_cnt  out  CNT_WIDTH  beats accepted with no enabled port

## Operation
- State: holding register data_q, pending mask pend[3:0], age counter, counters.
- Per-port handshake: hs[k] = pend[k] & M_AXIS_COPYk_tready. Completing ports clear pend[k] next edge.
- M_AXIS_COPYk_tvalid = pend[k]; M_AXIS_COPYk_tdata = data_q for all active ports.
- expire = (TIMEOUT_CYCLES != 0) & (age == TIMEOUT_CYCLES) & |(pend & ~hs).
- S_AXIS_DATA_tready = ~|(pend & ~hs) | expire (combinational from copy treadys; allows 1 beat/cycle).
- Input accept (tvalid & tready): data_q <= tdata; pend <= port_en & active_mask; age <= 0. If port_en & active_mask == 0 the beat is discarded, pend stays 0, discard_cnt += 1.
- No accept: pend <= pend & ~hs; on expire pend <= 0 and drop_cnt[k] += 1 for each k with pend[k] & ~hs[k].
- age increments while pend != 0 and no accept; holds at TIMEOUT_CYCLES.
- port_en changes while a beat is pending do not alter pend; new mask applies to the next beat.
- Counters saturate at all-ones; clr_cnt has priority over a same-cycle increment.
- busy = |pend.
- Ports k > N_PORTS: tvalid 0, tdata 0, tready ignored, drop_cnt field 0, never in active_mask.
- Reset mid-beat: pending beat lost, not counted.

## Timing
- Reset values: all tvalid 0, all tdata 0, data_q 0, pend 0, age 0, busy 0, all counters 0; S_AXIS_DATA_tready 1 during cycle after reset release.
- Latency: beat accepted at edge n shows tvalid on enabled ports from edge n (cycle n+1 sampling), one register stage.
- Throughput: 1 beat/cycle while all enabled treadys are high.
- tvalid on a port, once high, stays high with stable tdata until that port's handshake or expire (AXIS-compliant).
- Accept and final completion in same cycle: new beat loaded, no bubble.
- Expire and accept in same cycle: drops counted, new beat loaded.

## Test plan
- port_en=4'hF, all treadys 1, 8 beats 0x00..0x07 back-to-back -> each copy port sees 0x00..0x07 in order, one per cycle, tready never low, busy low after last.
- port_en=4'hF, COPY3_tready held 0 for 5 cycles, others 1 -> COPY1/2/4 tvalid drop after 1 cycle, S tready low 5 cycles, COPY3 receives beat on cycle 6, next beat accepted same cycle.
- TIMEOUT_CYCLES=4, COPY2_tready stuck 0 -> beat expires after 4 pending cycles, drop_cnt port 2 = 1, others 0, pipeline resumes; repeat 0xFFFF+2 times -> counter saturates at 0xFFFF; clr_cnt -> 0.
- port_en=4'h0, send 3 beats -> no tvalid on any port, tready 1, discard_cnt = 3.
- Beat 0xA5 pending with port_en=4'h3, change port_en to 4'hC before completion -> 0xA5 goes only to COPY1/2; next beat 0x5A goes only to COPY3/4.
- N_PORTS=2, port_en=4'hF -> COPY3/4 tvalid and tdata stay 0, beats flow on COPY1/2; assert rst with beat pending -> all tvalid 0 next cycle, counters 0.
